// File: rtl/wb_wr_buffer.sv
// Posted-write buffer between a Wishbone write master and a stalling/acking slave.
// Upstream writes are acked locally, queued, and drained with a bounded outstanding count.
module wb_wr_buffer #(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic [ADDR_W-1:0]         s_addr_i,
    input  logic [DATA_W-1:0]         s_data_i,
    input  logic [DATA_W/8-1:0]       s_sel_i,
    input  logic                      s_we_i,
    input  logic                      s_stb_i,
    output logic                      s_stall_o,
    output logic                      s_ack_o,
    output logic [ADDR_W-1:0]         m_addr_o,
    output logic [DATA_W-1:0]         m_data_o,
    output logic [DATA_W/8-1:0]       m_sel_o,
    output logic                      m_we_o,
    output logic                      m_stb_o,
    input  logic                      m_stall_i,
    input  logic                      m_ack_i,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      idle_o,
    output logic                      err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned SW = DATA_W / 8;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [SW-1:0]     sel_mem  [DEPTH];

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [3:0]    outs_q, outs_d;
    logic          ack_q, err_q, err_d, idle_q;

    logic full, accept, push, stb, pop, ack_ok, spurious;

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        accept   = s_stb_i & ~full;
        push     = accept & s_we_i & ~flush_i;
        // Flush suppresses the strobe, which also guarantees no pop that cycle.
        stb      = (level_q != '0) & (outs_q < 4'(MAX_OUTSTANDING)) & ~flush_i;
        pop      = stb & ~m_stall_i;
        ack_ok   = m_ack_i & ((outs_q != '0) | pop);
        spurious = m_ack_i & ~ack_ok;

        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        level_d = level_q + LW'(push) - LW'(pop);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end

        outs_d = outs_q + 4'(pop) - 4'(ack_ok);
        err_d  = err_q | (accept & ~s_we_i) | spurious;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            outs_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            outs_q  <= outs_d;
            ack_q   <= accept;
            err_q   <= err_d;
            idle_q  <= (level_d == '0) & (outs_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wptr_q] <= s_addr_i;
            data_mem[wptr_q] <= s_data_i;
            sel_mem[wptr_q]  <= s_sel_i;
        end
    end

    assign s_stall_o = full;
    assign s_ack_o   = ack_q;
    assign m_addr_o  = addr_mem[rptr_q];
    assign m_data_o  = data_mem[rptr_q];
    assign m_sel_o   = sel_mem[rptr_q];
    assign m_stb_o   = stb;
    assign m_we_o    = stb;
    assign level_o   = level_q;
    assign idle_o    = idle_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_wb_wr_buffer.sv
// Directed self-checking bench for wb_wr_buffer with default parameters.
module tb_wb_wr_buffer;

    logic        clk = 1'b0;
    logic        rst_ni, flush_i;
    logic [31:0] s_addr_i, s_data_i;
    logic [3:0]  s_sel_i;
    logic        s_we_i, s_stb_i, s_stall_o, s_ack_o;
    logic [31:0] m_addr_o, m_data_o;
    logic [3:0]  m_sel_o;
    logic        m_we_o, m_stb_o, m_stall_i, m_ack_i;
    logic [3:0]  level_o;
    logic        idle_o, err_o;

    logic        auto_ack, man_ack, ack_q;
    int          n_cmp, n_bad;
    int          ack_cnt = 0;
    int          iss_n   = 0;
    logic [31:0] iss_addr [0:255];

    wb_wr_buffer #(.DEPTH(8), .MAX_OUTSTANDING(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .s_addr_i(s_addr_i), .s_data_i(s_data_i), .s_sel_i(s_sel_i),
        .s_we_i(s_we_i), .s_stb_i(s_stb_i), .s_stall_o(s_stall_o), .s_ack_o(s_ack_o),
        .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_sel_o(m_sel_o),
        .m_we_o(m_we_o), .m_stb_o(m_stb_o), .m_stall_i(m_stall_i), .m_ack_i(m_ack_i),
        .level_o(level_o), .idle_o(idle_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Downstream slave: optional ack one cycle after each issue.
    always @(posedge clk) ack_q <= auto_ack && m_stb_o && !m_stall_i;
    assign m_ack_i = ack_q | man_ack;

    always @(posedge clk) begin
        if (s_ack_o) ack_cnt <= ack_cnt + 1;
        if (m_stb_o && !m_stall_i && iss_n < 256) begin
            iss_addr[iss_n] <= m_addr_o;
            iss_n <= iss_n + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_ni = 1'b0; flush_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
        s_addr_i = '0; s_data_i = '0; s_sel_i = '0; m_stall_i = 1'b0; man_ack = 1'b0;
        step();
        rst_ni = 1'b1;
    endtask

    task automatic put(input logic [31:0] a);
        s_stb_i = 1'b1; s_we_i = 1'b1; s_addr_i = a; s_data_i = ~a; s_sel_i = 4'hF;
    endtask

    task automatic test_reset;
        n_cmp++; if (level_o !== 4'd0) begin n_bad++; $display("FAIL rst_level: got %0d expected 0", level_o); end
        n_cmp++; if (idle_o !== 1'b1) begin n_bad++; $display("FAIL rst_idle: got %b expected 1", idle_o); end
        n_cmp++; if (s_stall_o !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", s_stall_o); end
        n_cmp++; if (s_ack_o !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %b expected 0", s_ack_o); end
        n_cmp++; if (m_stb_o !== 1'b0 || m_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_mstb: got stb=%b we=%b expected 0/0", m_stb_o, m_we_o); end
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", err_o); end
    endtask

    task automatic test_basic;
        int ib, ab;
        ib = iss_n; ab = ack_cnt;
        auto_ack = 1'b1; m_stall_i = 1'b0;
        put(32'h10);
        step();
        n_cmp++; if (s_ack_o !== 1'b1) begin n_bad++; $display("FAIL basic_ack0: got %b expected 1", s_ack_o); end
        n_cmp++; if (m_stb_o !== 1'b1 || m_addr_o !== 32'h10) begin n_bad++; $display("FAIL basic_first_issue: got stb=%b addr=%0h expected 1/10", m_stb_o, m_addr_o); end
        n_cmp++; if (m_data_o !== ~32'h10 || m_sel_o !== 4'hF) begin n_bad++; $display("FAIL basic_head_data: got %0h/%0h expected %0h/f", m_data_o, m_sel_o, ~32'h10); end
        put(32'h14);
        step();
        n_cmp++; if (s_ack_o !== 1'b1 || m_addr_o !== 32'h14) begin n_bad++; $display("FAIL basic_ack1: got ack=%b addr=%0h expected 1/14", s_ack_o, m_addr_o); end
        put(32'h18);
        step();
        n_cmp++; if (s_ack_o !== 1'b1) begin n_bad++; $display("FAIL basic_ack2: got %b expected 1", s_ack_o); end
        s_stb_i = 1'b0;
        for (int k = 0; k < 40 && idle_o !== 1'b1; k++) step();
        n_cmp++; if (idle_o !== 1'b1) begin n_bad++; $display("FAIL basic_idle: got %b expected 1", idle_o); end
        n_cmp++; if (ack_cnt - ab !== 3) begin n_bad++; $display("FAIL basic_ack_count: got %0d expected 3", ack_cnt - ab); end
        n_cmp++; if (iss_n - ib !== 3) begin n_bad++; $display("FAIL basic_issue_count: got %0d expected 3", iss_n - ib); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (iss_addr[ib + k] !== 32'h10 + 32'(4 * k)) begin
                n_bad++; $display("FAIL basic_order[%0d]: got %0h expected %0h", k, iss_addr[ib + k], 32'h10 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall_full;
        int ib, ab;
        ib = iss_n; ab = ack_cnt;
        auto_ack = 1'b1; m_stall_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put(32'h100 + 32'(4 * i));
            step();
            n_cmp++;
            if (level_o !== ((i < 7) ? 4'(i + 1) : 4'd8) || s_stall_o !== (i >= 7)) begin
                n_bad++; $display("FAIL full_fill[%0d]: got level=%0d stall=%b expected %0d/%b",
                                  i, level_o, s_stall_o, (i < 7) ? i + 1 : 8, i >= 7);
            end
        end
        s_stb_i = 1'b0;
        n_cmp++; if (ack_cnt - ab !== 8) begin n_bad++; $display("FAIL full_acks: got %0d expected 8", ack_cnt - ab); end
        n_cmp++; if (m_stb_o !== 1'b1 || m_addr_o !== 32'h100 || iss_n !== ib) begin n_bad++; $display("FAIL full_hold: got stb=%b addr=%0h issued=%0d expected 1/100/0", m_stb_o, m_addr_o, iss_n - ib); end
        m_stall_i = 1'b0;
        #1;
        n_cmp++; if (s_stall_o !== 1'b1) begin n_bad++; $display("FAIL full_no_bypass: got %b expected 1", s_stall_o); end
        step();
        n_cmp++; if (s_stall_o !== 1'b0 || level_o !== 4'd7) begin n_bad++; $display("FAIL full_release: got stall=%b level=%0d expected 0/7", s_stall_o, level_o); end
        for (int k = 0; k < 40 && idle_o !== 1'b1; k++) step();
        n_cmp++; if (iss_n - ib !== 8 || idle_o !== 1'b1) begin n_bad++; $display("FAIL full_drain: got issued=%0d idle=%b expected 8/1", iss_n - ib, idle_o); end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (iss_addr[ib + k] !== 32'h100 + 32'(4 * k)) begin
                n_bad++; $display("FAIL full_order[%0d]: got %0h expected %0h", k, iss_addr[ib + k], 32'h100 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_max_outstanding;
        int ib;
        ib = iss_n;
        auto_ack = 1'b0; m_stall_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            put(32'h200 + 32'(4 * i));
            step();
        end
        s_stb_i = 1'b0;
        n_cmp++; if (level_o !== 4'd2 || m_stb_o !== 1'b0) begin n_bad++; $display("FAIL maxo_block: got level=%0d stb=%b expected 2/0", level_o, m_stb_o); end
        step();
        n_cmp++; if (iss_n - ib !== 4 || m_stb_o !== 1'b0 || level_o !== 4'd2) begin n_bad++; $display("FAIL maxo_held: got issued=%0d stb=%b level=%0d expected 4/0/2", iss_n - ib, m_stb_o, level_o); end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_cmp++; if (m_stb_o !== 1'b1 || iss_n - ib !== 4) begin n_bad++; $display("FAIL maxo_reopen: got stb=%b issued=%0d expected 1/4", m_stb_o, iss_n - ib); end
        step();
        n_cmp++; if (iss_n - ib !== 5 || m_stb_o !== 1'b0 || level_o !== 4'd1) begin n_bad++; $display("FAIL maxo_one_more: got issued=%0d stb=%b level=%0d expected 5/0/1", iss_n - ib, m_stb_o, level_o); end
        n_cmp++; if (iss_addr[ib + 4] !== 32'h210) begin n_bad++; $display("FAIL maxo_addr: got %0h expected 210", iss_addr[ib + 4]); end
    endtask

    task automatic test_flush;
        int ib;
        ib = iss_n;
        auto_ack = 1'b0; m_stall_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            put(32'h300 + 32'(4 * i));
            step();
        end
        s_stb_i = 1'b0; m_stall_i = 1'b0;
        step();
        step();
        m_stall_i = 1'b1;
        put(32'h318);
        step();
        n_cmp++; if (level_o !== 4'd5 || iss_n - ib !== 2) begin n_bad++; $display("FAIL flush_setup: got level=%0d issued=%0d expected 5/2", level_o, iss_n - ib); end
        m_stall_i = 1'b0; flush_i = 1'b1;
        put(32'h3FC);
        #1;
        n_cmp++; if (m_stb_o !== 1'b0 || s_stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_cycle_stb: got stb=%b stall=%b expected 0/0", m_stb_o, s_stall_o); end
        step();
        flush_i = 1'b0; s_stb_i = 1'b0;
        n_cmp++; if (s_ack_o !== 1'b1 || level_o !== 4'd0) begin n_bad++; $display("FAIL flush_ack_level: got ack=%b level=%0d expected 1/0", s_ack_o, level_o); end
        n_cmp++; if (m_stb_o !== 1'b0 || idle_o !== 1'b0 || iss_n - ib !== 2) begin n_bad++; $display("FAIL flush_after: got stb=%b idle=%b issued=%0d expected 0/0/2", m_stb_o, idle_o, iss_n - ib); end
        step();
        n_cmp++; if (m_stb_o !== 1'b0 || idle_o !== 1'b0) begin n_bad++; $display("FAIL flush_quiet: got stb=%b idle=%b expected 0/0", m_stb_o, idle_o); end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_cmp++; if (idle_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle_early: got %b expected 0", idle_o); end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_cmp++; if (idle_o !== 1'b1 || err_o !== 1'b0) begin n_bad++; $display("FAIL flush_idle_final: got idle=%b err=%b expected 1/0", idle_o, err_o); end
    endtask

    task automatic test_errors;
        do_reset();
        s_stb_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h40;
        step();
        s_stb_i = 1'b0;
        n_cmp++; if (s_ack_o !== 1'b1 || level_o !== 4'd0 || err_o !== 1'b1) begin n_bad++; $display("FAIL err_read: got ack=%b level=%0d err=%b expected 1/0/1", s_ack_o, level_o, err_o); end
        step();
        n_cmp++; if (err_o !== 1'b1 || s_ack_o !== 1'b0) begin n_bad++; $display("FAIL err_sticky: got err=%b ack=%b expected 1/0", err_o, s_ack_o); end
        do_reset();
        n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b expected 0", err_o); end
        man_ack = 1'b1;
        step();
        man_ack = 1'b0;
        n_cmp++; if (err_o !== 1'b1 || idle_o !== 1'b1) begin n_bad++; $display("FAIL err_spurious_ack: got err=%b idle=%b expected 1/1", err_o, idle_o); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        auto_ack = 1'b0; m_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put(32'h500 + 32'(4 * i));
            step();
        end
        s_stb_i = 1'b0; m_stall_i = 1'b0;
        step();
        step();
        m_stall_i = 1'b1;
        n_cmp++; if (level_o !== 4'd3 || idle_o !== 1'b0) begin n_bad++; $display("FAIL rmid_setup: got level=%0d idle=%b expected 3/0", level_o, idle_o); end
        rst_ni = 1'b0;
        put(32'h5FC);
        step();
        rst_ni = 1'b1; s_stb_i = 1'b0; m_stall_i = 1'b0;
        n_cmp++; if (level_o !== 4'd0 || idle_o !== 1'b1) begin n_bad++; $display("FAIL rmid_state: got level=%0d idle=%b expected 0/1", level_o, idle_o); end
        n_cmp++; if (s_ack_o !== 1'b0 || m_stb_o !== 1'b0 || err_o !== 1'b0) begin n_bad++; $display("FAIL rmid_outputs: got ack=%b stb=%b err=%b expected 0/0/0", s_ack_o, m_stb_o, err_o); end
        step();
        n_cmp++; if (m_stb_o !== 1'b0 || level_o !== 4'd0) begin n_bad++; $display("FAIL rmid_empty: got stb=%b level=%0d expected 0/0", m_stb_o, level_o); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        auto_ack = 1'b0;
        do_reset();
        step();
        test_reset();
        test_basic();
        test_stall_full();
        do_reset();
        test_max_outstanding();
        do_reset();
        test_flush();
        test_errors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/wb_wr_buffer.md
Name: wb_wr_buffer

Overview:
- Posted-write FIFO between the usb_sniffer Wishbone write master and port A of the sample RAM.
- Replaces the tied-off stall path, so sniffer writes are absorbed and acked locally, then drained to the RAM while honouring its stall and ack.
- Adds `idle_o` so capture-stop logic can tell when every captured word has actually landed in RAM.

Parameters:
- DEPTH, 8, number of buffered write entries; power of 2, minimum 2.
- MAX_OUTSTANDING, 4, maximum issued-but-unacked downstream writes; 1 to 15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; select width is DATA_W/8.

Ports:
- clk_i  in  1  clock; single domain.
- rst_ni  in  1  reset, synchronous, active-low.
- flush_i  in  1  synchronous discard of all queued entries.
- s_addr_i  in  ADDR_W  upstream write address.
- s_data_i  in  DATA_W  upstream write data.
- s_sel_i  in  DATA_W/8  upstream byte selects.
- s_we_i  in  1  upstream write enable.
- s_stb_i  in  1  upstream strobe.
- s_stall_o  out  1  upstream stall.
- s_ack_o  out  1  upstream ack.
- m_addr_o  out  ADDR_W  downstream address (FIFO head).
- m_data_o  out  DATA_W  downstream data (FIFO head).
- m_sel_o  out  DATA_W/8  downstream selects (FIFO head).
- m_we_o  out  1  downstream write enable.
- m_stb_o  out  1  downstream strobe.
- m_stall_i  in  1  downstream stall.
- m_ack_i  in  1  downstream ack.
- level_o  out  clog2(DEPTH)+1  current entry count.
- idle_o  out  1  FIFO empty and zero outstanding.
- err_o  out  1  sticky error flag.

Behaviour:
- **Reset** (rst_ni low at a clk_i edge) clears:
  - FIFO pointers, level_o and the outstanding counter to 0;
  - s_stall_o, s_ack_o, m_stb_o, m_we_o and err_o to 0;
  - idle_o to 1.
- Reset mid-operation drops all queued and outstanding writes; no ack is generated for them.
- **Accept**: a transfer is accepted when `s_stb_i & ~s_stall_o`.
  - `s_stall_o = (level == DEPTH)`, decoded from registered level only; there is no same-cycle bypass on pop.
  - A full FIFO therefore stalls even in a cycle where it is popping.
- **Upstream ack**: s_ack_o pulses exactly 1 cycle after each accepted transfer (posted write), one ack per accept, for back-to-back accepts too.
- **Non-write strobes**: an accepted transfer with s_we_i=0 is acked but not queued, and sets err_o.
- **Queued entry**: {addr, data, sel} from an accepted write is stored at the write pointer, which then increments modulo DEPTH.
- **Downstream issue**:
  - `m_stb_o = (level != 0) & (outstanding < MAX_OUTSTANDING)`; m_we_o equals m_stb_o.
  - m_addr_o, m_data_o and m_sel_o present the head entry; they are only meaningful while m_stb_o is high.
  - Issue occurs when `m_stb_o & ~m_stall_i`. On issue: read pointer +1 (mod DEPTH), level −1, outstanding +1.
  - Head fields stay stable while stalled.
- **Latency**: a write accepted in cycle N is presented on m_stb_o in cycle N+1 at the earliest.
- **Downstream ack**: m_ack_i decrements outstanding.
  - If issue and ack coincide, outstanding is unchanged.
  - m_ack_i while outstanding == 0 with no issue in the same cycle is ignored and sets err_o.
- **Level update**: `level_next = level + push − pop`. Simultaneous push and pop leaves level unchanged. Pointers wrap silently.
- **Flush**: flush_i=1 sets both pointers equal and level to 0 next cycle; m_stb_o is 0 during the flush cycle.
  - A write accepted during the flush cycle is acked but discarded.
  - Flush has priority over push and pop.
  - The outstanding counter is not cleared; acks for already-issued writes are still consumed.
- **Idle**: `idle_o = (level == 0) & (outstanding == 0)`, registered.
- **Error flag**: err_o is sticky until reset.

Test Plan:
- 3 back-to-back upstream writes (A=0x10,0x14,0x18), m_stall_i=0, m_ack_i one cycle after each issue:
  - 3 s_ack_o pulses, each 1 cycle after its accept;
  - m_addr_o sequence 0x10,0x14,0x18 with first m_stb_o 1 cycle after first accept;
  - idle_o returns to 1.
- m_stall_i=1, 10 consecutive upstream write strobes, DEPTH=8:
  - s_stall_o rises once level_o=8; exactly 8 acks;
  - release stall → 8 entries drained in order; s_stall_o drops the cycle after the first pop.
- m_ack_i withheld, m_stall_i=0, 6 writes queued, MAX_OUTSTANDING=4:
  - exactly 4 issues and m_stb_o=0 with level_o=2;
  - one m_ack_i → one further issue next cycle.
- 5 entries queued, flush_i pulsed with a concurrent accepted write:
  - that write is acked; level_o=0 next cycle; no further m_stb_o;
  - idle_o=1 only after pending acks return.
- Error cases:
  - s_stb_i with s_we_i=0 → ack, level_o unchanged, err_o=1;
  - after reset, spurious m_ack_i at idle → err_o=1.
- rst_ni low for 1 cycle with 3 entries queued and 2 outstanding:
  - level_o=0, idle_o=1, s_ack_o=0, m_stb_o=0 and err_o=0 on the next cycle.
